distance_occupancy_filter: RTL



---
 rtl/distance_pkg.sv | 19 +
 rtl/moving_avg4.sv | 68 ++++++
 rtl/distance_occupancy_filter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/distance_pkg.sv
// Shared types and default tuning constants for the distance/occupancy filter.
package distance_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        ARRIVING = 2'd1,
        OCCUPIED = 2'd2,
        LEAVING  = 2'd3
    } occ_state_t;

    localparam int          WINDOW_LEN          = 4;
    localparam logic [15:0] DEF_NEAR_THRESH     = 16'd300;
    localparam logic [15:0] DEF_FAR_THRESH      = 16'd400;
    localparam logic [15:0] DEF_MAX_VALID       = 16'd4000;
    localparam int unsigned DEF_CONFIRM         = 3;
    localparam int unsigned DEF_BAD_LIMIT       = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 50_000_000;

endpackage

// File: rtl/moving_avg4.sv
// Four-entry moving average over accepted samples; publishes an average only
// once the window has been completely refilled since reset or the last flush.
module moving_avg4
    import distance_pkg::*;
(
    input  logic        clk,
    input  logic        reset_l,
    input  logic        shift_en,
    input  logic        flush,
    input  logic [15:0] din,
    output logic [15:0] avg,
    output logic        avg_valid
);

    logic [15:0] win_q [WINDOW_LEN];
    logic [15:0] win_d [WINDOW_LEN];
    logic [2:0]  fill_q, fill_d;
    logic [15:0] avg_q, avg_d;
    logic        avg_valid_q, avg_valid_d;
    logic [17:0] sum;

    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        sum         = '0;
        if (flush) begin
            fill_d = '0;
        end else if (shift_en) begin
            win_d[0] = din;
            for (int i = 1; i < WINDOW_LEN; i++) begin
                win_d[i] = win_q[i-1];
            end
            if (fill_q != 3'(WINDOW_LEN)) begin
                fill_d = fill_q + 3'd1;
            end
        end
        // Stale entries left after a flush are all overwritten before fill_d reaches 4.
        for (int i = 0; i < WINDOW_LEN; i++) begin
            sum = sum + 18'(win_d[i]);
        end
        if (shift_en && !flush && fill_d == 3'(WINDOW_LEN)) begin
            avg_valid_d = 1'b1;
            avg_d       = sum[17:2];
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
                win_q[i] <= '0;
            end
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/distance_occupancy_filter.sv
// Averages ultrasonic distance samples, debounces car occupancy with hysteresis
// and flags a broken sensor on runs of bad samples or a lack of samples.
module distance_occupancy_filter
    import distance_pkg::*;
#(
    parameter logic [15:0] NEAR_THRESH    = DEF_NEAR_THRESH,
    parameter logic [15:0] FAR_THRESH     = DEF_FAR_THRESH,
    parameter logic [15:0] MAX_VALID      = DEF_MAX_VALID,
    parameter int unsigned CONFIRM        = DEF_CONFIRM,
    parameter int unsigned BAD_LIMIT      = DEF_BAD_LIMIT,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic [15:0] avg_distance,
    output logic        avg_valid,
    output logic        car_present,
    output logic        car_change,
    output logic        sensor_broken,
    output logic [1:0]  occ_state
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic              sample_ok;
    logic              flush;
    logic [7:0]        bad_cnt_q, bad_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              broken_q, broken_d;
    occ_state_t        state_q, state_d;
    logic [3:0]        confirm_cnt_q, confirm_cnt_d;
    logic              car_q, car_d;
    logic              change_q, change_d;
    logic              near, far;

    assign sample_ok = sample_valid && (sample_data != 16'd0) && (sample_data <= MAX_VALID);
    // Window restarts from empty only on the broken rising edge.
    assign flush     = broken_d && !broken_q;

    moving_avg4 u_avg (
        .clk       (clk),
        .reset_l   (reset_l),
        .shift_en  (sample_ok),
        .flush     (flush),
        .din       (sample_data),
        .avg       (avg_distance),
        .avg_valid (avg_valid)
    );

    always_comb begin
        bad_cnt_d = bad_cnt_q;
        idle_d    = idle_q;
        broken_d  = broken_q;
        if (sample_valid) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LAST) begin
            idle_d = idle_q + 1'b1;
        end
        // Any sample, even a bad one, pre-empts the timeout on its terminal cycle.
        if (sample_ok) begin
            bad_cnt_d = '0;
            broken_d  = 1'b0;
        end else if (sample_valid) begin
            if (bad_cnt_q != 8'hFF) begin
                bad_cnt_d = bad_cnt_q + 8'd1;
            end
            if (32'(bad_cnt_d) >= BAD_LIMIT) begin
                broken_d = 1'b1;
            end
        end else if (idle_q == IDLE_LAST) begin
            broken_d = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        confirm_cnt_d = confirm_cnt_q;
        change_d      = 1'b0;
        near          = avg_distance < NEAR_THRESH;
        far           = avg_distance > FAR_THRESH;
        if (avg_valid && !broken_q) begin
            unique case (state_q)
                EMPTY: begin
                    if (near) begin
                        if (CONFIRM == 1) begin
                            state_d  = OCCUPIED;
                            change_d = 1'b1;
                        end else begin
                            state_d       = ARRIVING;
                            confirm_cnt_d = 4'd1;
                        end
                    end
                end
                ARRIVING: begin
                    if (!near) begin
                        state_d       = EMPTY;
                        confirm_cnt_d = '0;
                    end else if (32'(confirm_cnt_q) + 32'd1 >= CONFIRM) begin
                        state_d       = OCCUPIED;
                        confirm_cnt_d = '0;
                        change_d      = 1'b1;
                    end else begin
                        confirm_cnt_d = confirm_cnt_q + 4'd1;
                    end
                end
                OCCUPIED: begin
                    if (far) begin
                        if (CONFIRM == 1) begin
                            state_d  = EMPTY;
                            change_d = 1'b1;
                        end else begin
                            state_d       = LEAVING;
                            confirm_cnt_d = 4'd1;
                        end
                    end
                end
                LEAVING: begin
                    if (!far) begin
                        state_d       = OCCUPIED;
                        confirm_cnt_d = '0;
                    end else if (32'(confirm_cnt_q) + 32'd1 >= CONFIRM) begin
                        state_d       = EMPTY;
                        confirm_cnt_d = '0;
                        change_d      = 1'b1;
                    end else begin
                        confirm_cnt_d = confirm_cnt_q + 4'd1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        car_d = (state_d == OCCUPIED) || (state_d == LEAVING);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            bad_cnt_q     <= '0;
            idle_q        <= '0;
            broken_q      <= 1'b0;
            state_q       <= EMPTY;
            confirm_cnt_q <= '0;
            car_q         <= 1'b0;
            change_q      <= 1'b0;
        end else begin
            bad_cnt_q     <= bad_cnt_d;
            idle_q        <= idle_d;
            broken_q      <= broken_d;
            state_q       <= state_d;
            confirm_cnt_q <= confirm_cnt_d;
            car_q         <= car_d;
            change_q      <= change_d;
        end
    end

    assign car_present   = car_q;
    assign car_change    = change_q;
    assign sensor_broken = broken_q;
    assign occ_state     = state_q;

endmodule
